// File: rtl/e203_exu_lpipe_sb_pkg.sv
// rtl/e203_exu_lpipe_sb_pkg.sv - shared e203 defaults and long-pipe scoreboard entry layout
package e203_exu_lpipe_sb_pkg;

    localparam int E203_LPIPE_SB_DEPTH   = 2;
    localparam int E203_LPIPE_SB_RFIDX_W = 5;
    localparam int E203_LPIPE_SB_PC_W    = 32;

    // Entry payload is packed as {pc, rdidx, rdfpu, rdwen}, LSB first
    localparam int ENT_RDWEN_BIT = 0;
    localparam int ENT_RDFPU_BIT = 1;
    localparam int ENT_RDIDX_LSB = 2;

    function automatic int ent_pc_lsb(input int rfidx_w);
        return ENT_RDIDX_LSB + rfidx_w;
    endfunction

    function automatic int ent_w(input int rfidx_w, input int pc_w);
        return ENT_RDIDX_LSB + rfidx_w + pc_w;
    endfunction

endpackage

// File: rtl/e203_exu_lpipe_sb_if.sv
// rtl/e203_exu_lpipe_sb_if.sv - allocate/retire/dispatch-match bundle of the long-pipe scoreboard
interface e203_exu_lpipe_sb_if
    import e203_exu_lpipe_sb_pkg::*;
#(
    parameter int DEPTH   = E203_LPIPE_SB_DEPTH,
    parameter int RFIDX_W = E203_LPIPE_SB_RFIDX_W,
    parameter int PC_W    = E203_LPIPE_SB_PC_W
) ();
    localparam int ITAG_W = $clog2(DEPTH);

    logic                 alc_ena;
    logic                 alc_ready;
    logic [ITAG_W-1:0]    alc_ptr;
    logic                 alc_rdwen;
    logic                 alc_rdfpu;
    logic [RFIDX_W-1:0]   alc_rdidx;
    logic [PC_W-1:0]      alc_pc;

    logic                 ret_ena;
    logic [ITAG_W-1:0]    ret_ptr;
    logic                 ret_rdwen;
    logic                 ret_rdfpu;
    logic [RFIDX_W-1:0]   ret_rdidx;
    logic [PC_W-1:0]      ret_pc;

    logic [2:0]           dis_rsen;
    logic [2:0]           dis_rsfpu;
    logic [3*RFIDX_W-1:0] dis_rsidx;
    logic                 dis_rdwen;
    logic                 dis_rdfpu;
    logic [RFIDX_W-1:0]   dis_rdidx;
    logic [2:0]           match_rs;
    logic                 match_rd;

    logic                 empty;
    logic [ITAG_W:0]      count;

    modport slave (
        input  alc_ena, alc_rdwen, alc_rdfpu, alc_rdidx, alc_pc, ret_ena,
               dis_rsen, dis_rsfpu, dis_rsidx, dis_rdwen, dis_rdfpu, dis_rdidx,
        output alc_ready, alc_ptr, ret_ptr, ret_rdwen, ret_rdfpu, ret_rdidx, ret_pc,
               match_rs, match_rd, empty, count
    );

    modport master (
        output alc_ena, alc_rdwen, alc_rdfpu, alc_rdidx, alc_pc, ret_ena,
               dis_rsen, dis_rsfpu, dis_rsidx, dis_rdwen, dis_rdfpu, dis_rdidx,
        input  alc_ready, alc_ptr, ret_ptr, ret_rdwen, ret_rdfpu, ret_rdidx, ret_pc,
               match_rs, match_rd, empty, count
    );

endinterface

// File: rtl/e203_exu_lpipe_sb_ptr.sv
// rtl/e203_exu_lpipe_sb_ptr.sv - circular pointer with wrap bit
module e203_exu_lpipe_sb_ptr #(
    parameter int AW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [AW-1:0] ptr,
    output logic          wrap
);
    // The wrap bit is the carry out of the index; depth is a power of two so
    // a plain increment wraps the index and toggles the wrap bit together.
    logic [AW:0] ptr_q;
    logic [AW:0] ptr_d;

    // Advance by one when incremented
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Pointer register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr  = ptr_q[AW-1:0];
    assign wrap = ptr_q[AW];

endmodule

// File: rtl/e203_exu_lpipe_sb.sv
// rtl/e203_exu_lpipe_sb.sv - long-pipe outstanding-write scoreboard; optional E203_LPIPE_SB_RET_BYPASS_EN
module e203_exu_lpipe_sb
    import e203_exu_lpipe_sb_pkg::*;
#(
    parameter int DEPTH   = E203_LPIPE_SB_DEPTH,
    parameter int RFIDX_W = E203_LPIPE_SB_RFIDX_W,
    parameter int PC_W    = E203_LPIPE_SB_PC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    e203_exu_lpipe_sb_if.slave sb
);
    localparam int ITAG_W = $clog2(DEPTH);
    localparam int ENT_W  = ent_w(RFIDX_W, PC_W);
    localparam int PC_LSB = ent_pc_lsb(RFIDX_W);

    logic [ITAG_W-1:0] alc_ptr;
    logic [ITAG_W-1:0] ret_ptr;
    logic              alc_wrap;
    logic              ret_wrap;
    logic              empty;
    logic              full;
    logic              alc_ready;
    logic              alc_fire;
    logic              ret_fire;

    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;
    logic [ENT_W-1:0]  ent_q [DEPTH];
    logic [ENT_W-1:0]  ent_d [DEPTH];
    logic [ENT_W-1:0]  head;
    logic [DEPTH-1:0]  live;
    logic [2:0]        rs_hit;
    logic              rd_hit;

    assign empty = (alc_ptr == ret_ptr) && (alc_wrap == ret_wrap);
    assign full  = (alc_ptr == ret_ptr) && (alc_wrap != ret_wrap);

`ifdef E203_LPIPE_SB_RET_BYPASS_EN
    // A retirement frees the head slot in the same cycle, so a full buffer can still accept
    assign alc_ready = ~full | sb.ret_ena;
`else
    assign alc_ready = ~full;
`endif

    assign alc_fire = sb.alc_ena & alc_ready;
    assign ret_fire = sb.ret_ena & ~empty;

    e203_exu_lpipe_sb_ptr #(.AW(ITAG_W)) u_alc_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (alc_fire),
        .ptr   (alc_ptr),
        .wrap  (alc_wrap)
    );

    e203_exu_lpipe_sb_ptr #(.AW(ITAG_W)) u_ret_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ret_fire),
        .ptr   (ret_ptr),
        .wrap  (ret_wrap)
    );

    // Valid bits: clear the retiring head, then set the allocated slot (same slot when full+bypass)
    always_comb begin
        vld_d = vld_q;
        if (ret_fire) begin
            vld_d[ret_ptr] = 1'b0;
        end
        if (alc_fire) begin
            vld_d[alc_ptr] = 1'b1;
        end
    end

    // Valid register, cleared by reset so in-flight entries are discarded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload write at the allocation slot
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (alc_fire) begin
            ent_d[alc_ptr] = {sb.alc_pc, sb.alc_rdidx, sb.alc_rdfpu, sb.alc_rdwen};
        end
    end

    // Payload storage is left unreset; it is ignored while its valid bit is low
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    // RAW/WAW lookup of the dispatching instruction against live entries
    always_comb begin
        live = vld_q;
`ifdef E203_LPIPE_SB_RET_BYPASS_EN
        if (ret_fire) begin
            live[ret_ptr] = 1'b0;
        end
`endif
        rs_hit = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 3; s++) begin
                if (live[i] && ent_q[i][ENT_RDWEN_BIT]
                    && (ent_q[i][ENT_RDIDX_LSB +: RFIDX_W] == sb.dis_rsidx[s*RFIDX_W +: RFIDX_W])
                    && (ent_q[i][ENT_RDFPU_BIT] == sb.dis_rsfpu[s])) begin
                    rs_hit[s] = 1'b1;
                end
            end
            if (live[i] && ent_q[i][ENT_RDWEN_BIT]
                && (ent_q[i][ENT_RDIDX_LSB +: RFIDX_W] == sb.dis_rdidx)
                && (ent_q[i][ENT_RDFPU_BIT] == sb.dis_rdfpu)) begin
                rd_hit = 1'b1;
            end
        end
    end

    assign head         = ent_q[ret_ptr];
    assign sb.alc_ready = alc_ready;
    assign sb.alc_ptr   = alc_ptr;
    assign sb.ret_ptr   = ret_ptr;
    assign sb.ret_rdwen = head[ENT_RDWEN_BIT] & ~empty;
    assign sb.ret_rdfpu = head[ENT_RDFPU_BIT];
    assign sb.ret_rdidx = head[ENT_RDIDX_LSB +: RFIDX_W];
    assign sb.ret_pc    = head[PC_LSB +: PC_W];
    assign sb.match_rs  = rs_hit & sb.dis_rsen;
    assign sb.match_rd  = rd_hit & sb.dis_rdwen;
    assign sb.empty     = empty;
    assign sb.count     = {alc_wrap, alc_ptr} - {ret_wrap, ret_ptr};

endmodule

// File: tb/tb_e203_exu_lpipe_sb.sv
// tb/tb_e203_exu_lpipe_sb.sv - scoreboard-checked directed bench for e203_exu_lpipe_sb
module tb_e203_exu_lpipe_sb;

    localparam int DEPTH   = 2;
    localparam int RFIDX_W = 5;
    localparam int PC_W    = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    e203_exu_lpipe_sb_if #(.DEPTH(DEPTH), .RFIDX_W(RFIDX_W), .PC_W(PC_W)) sb_if ();

    e203_exu_lpipe_sb #(.DEPTH(DEPTH), .RFIDX_W(RFIDX_W), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if.slave)
    );

    typedef struct {
        string name;
        int    cnt;
        int    emp;
        int    rdy;
        int    aptr;
        int    rptr;
        int    rwen;
        int    pc;
        int    mrs;
        int    mrd;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic cmp(input string tag, input string fld, input int act, input int req);
        if (act != req) begin
            n_mis++;
            $display("FAIL %s.%s actual=%0d required=%0d", tag, fld, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            cmp(e.name, "count",     int'(sb_if.count),     e.cnt);
            cmp(e.name, "empty",     int'(sb_if.empty),     e.emp);
            cmp(e.name, "alc_ready", int'(sb_if.alc_ready), e.rdy);
            cmp(e.name, "alc_ptr",   int'(sb_if.alc_ptr),   e.aptr);
            cmp(e.name, "ret_ptr",   int'(sb_if.ret_ptr),   e.rptr);
            cmp(e.name, "ret_rdwen", int'(sb_if.ret_rdwen), e.rwen);
            cmp(e.name, "match_rs",  int'(sb_if.match_rs),  e.mrs);
            cmp(e.name, "match_rd",  int'(sb_if.match_rd),  e.mrd);
            if (e.emp == 0) begin
                cmp(e.name, "ret_pc", int'(sb_if.ret_pc), e.pc);
            end
        end
    end

    // Queue the expected outputs for the current input set, then advance one cycle
    task automatic expect_cyc(input string n, input int cnt, input int emp, input int rdy,
                              input int aptr, input int rptr, input int rwen, input int pc,
                              input int mrs, input int mrd);
        exp_t e;
        e.name = n; e.cnt = cnt; e.emp = emp; e.rdy = rdy; e.aptr = aptr;
        e.rptr = rptr; e.rwen = rwen; e.pc = pc; e.mrs = mrs; e.mrd = mrd;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.alc_ena   = 1'b0;
        sb_if.alc_rdwen = 1'b0;
        sb_if.alc_rdfpu = 1'b0;
        sb_if.alc_rdidx = '0;
        sb_if.alc_pc    = '0;
        sb_if.ret_ena   = 1'b0;
        sb_if.dis_rsen  = '0;
        sb_if.dis_rsfpu = '0;
        sb_if.dis_rsidx = '0;
        sb_if.dis_rdwen = 1'b0;
        sb_if.dis_rdfpu = 1'b0;
        sb_if.dis_rdidx = '0;
    endtask

    task automatic alloc(input int rdidx, input logic rdfpu, input int pc);
        sb_if.alc_ena   = 1'b1;
        sb_if.alc_rdwen = 1'b1;
        sb_if.alc_rdfpu = rdfpu;
        sb_if.alc_rdidx = RFIDX_W'(rdidx);
        sb_if.alc_pc    = PC_W'(pc);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_cyc("reset", 0, 1, 1, 0, 0, 0, 0, 0, 0);

        // First allocation, then RAW/WAW hit on rd 5 (rs2 matches index but is not enabled)
        alloc(5, 1'b0, 100);
        sb_if.dis_rsen  = 3'b001;
        sb_if.dis_rsidx = {5'd0, 5'd5, 5'd5};
        sb_if.dis_rdwen = 1'b1;
        sb_if.dis_rdidx = 5'd5;
        expect_cyc("a1_pre", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        sb_if.alc_ena = 1'b0;
        expect_cyc("a1", 1, 0, 1, 1, 0, 1, 100, 1, 1);
        idle();
        sb_if.ret_ena = 1'b1;
        expect_cyc("r1", 1, 0, 1, 1, 0, 1, 100, 0, 0);
        idle();
        expect_cyc("r1_post", 0, 1, 1, 1, 1, 0, 0, 0, 0);

        // FPU flag must match; retire while empty is ignored during the allocate
        alloc(3, 1'b1, 200);
        sb_if.ret_ena = 1'b1;
        expect_cyc("a2_pre", 0, 1, 1, 1, 1, 0, 0, 0, 0);
        idle();
        sb_if.dis_rsen  = 3'b001;
        sb_if.dis_rsidx = {5'd0, 5'd0, 5'd3};
        sb_if.dis_rsfpu = 3'b000;
        expect_cyc("fpu0", 1, 0, 1, 0, 1, 1, 200, 0, 0);
        sb_if.dis_rsfpu = 3'b001;
        sb_if.dis_rdwen = 1'b1;
        sb_if.dis_rdfpu = 1'b1;
        sb_if.dis_rdidx = 5'd3;
        alloc(7, 1'b0, 300);
        expect_cyc("fpu1", 1, 0, 1, 0, 1, 1, 200, 1, 1);

        // Full: extra allocate ignored
        idle();
        alloc(9, 1'b0, 400);
        expect_cyc("full_a", 2, 0, 0, 1, 1, 1, 200, 0, 0);
        sb_if.alc_ena = 1'b0;
        expect_cyc("full_b", 2, 0, 0, 1, 1, 1, 200, 0, 0);

        // Full with simultaneous allocate and retire; dispatch reads the retiring rd 3
        alloc(11, 1'b0, 500);
        sb_if.ret_ena   = 1'b1;
        sb_if.dis_rsen  = 3'b001;
        sb_if.dis_rsidx = {5'd0, 5'd0, 5'd3};
        sb_if.dis_rsfpu = 3'b001;
`ifdef E203_LPIPE_SB_RET_BYPASS_EN
        expect_cyc("full_ar", 2, 0, 1, 1, 1, 1, 200, 0, 0);
        sb_if.alc_ena = 1'b0;
        sb_if.ret_ena = 1'b0;
        expect_cyc("full_ar_post", 2, 0, 0, 0, 0, 1, 300, 0, 0);
`else
        expect_cyc("full_ar", 2, 0, 0, 1, 1, 1, 200, 1, 0);
        sb_if.alc_ena = 1'b0;
        sb_if.ret_ena = 1'b0;
        expect_cyc("full_ar_post", 1, 0, 1, 1, 0, 1, 300, 0, 0);
        idle();
        alloc(13, 1'b0, 600);
        expect_cyc("refill", 1, 0, 1, 1, 0, 1, 300, 0, 0);
`endif

        // Reset wins over simultaneous allocate and retire with two live entries
        idle();
        rst_n = 1'b0;
        alloc(15, 1'b0, 700);
        sb_if.ret_ena = 1'b1;
`ifdef E203_LPIPE_SB_RET_BYPASS_EN
        expect_cyc("rst2", 2, 0, 1, 0, 0, 1, 300, 0, 0);
`else
        expect_cyc("rst2", 2, 0, 0, 0, 0, 1, 300, 0, 0);
`endif
        idle();
        rst_n = 1'b1;
        expect_cyc("rst2_post", 0, 1, 1, 0, 0, 0, 0, 0, 0);

        // Wrap-around: alternating allocate (with ignored empty retire) and retire
        for (int k = 0; k < 5; k++) begin
            alloc(k + 1, 1'b0, 32'h1000 + k);
            sb_if.ret_ena = 1'b1;
            expect_cyc($sformatf("wrap_a%0d", k), 0, 1, 1, k % 2, k % 2, 0, 0, 0, 0);
            idle();
            sb_if.ret_ena = 1'b1;
            expect_cyc($sformatf("wrap_r%0d", k), 1, 0, 1, (k + 1) % 2, k % 2, 1, 32'h1000 + k, 0, 0);
        end
        idle();
        expect_cyc("wrap_end", 0, 1, 1, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
